// File: rtl/alarm_ring_controller.sv
// -----------------------------------------------------------------------------
// alarm_ring_controller
//
// Sequences the alarm once the current time reaches the alarm setting. It
// handles ringing, snooze, dismiss and auto-timeout, and it generates the
// buzzer beep pattern. Everything runs on clk_200. One-second timing comes
// from the single-cycle sec_tick strobe.
//
// Ports:
//   clk_200      in   200 Hz system clock
//   rst          in   asynchronous, active-high reset
//   sec_tick     in   one-cycle pulse per second
//   time_hhmm    in   current time, BCD HHMM
//   alarm_hhmm   in   alarm setting, BCD HHMM
//   time_ss      in   current seconds, BCD
//   alarm_en     in   alarm armed (level)
//   adjusting    in   user is in a time/alarm adjust mode (blocks new trigger)
//   btn_dismiss  in   dismiss pulse
//   btn_snooze   in   snooze pulse
//   ringing      out  high while ringing
//   snoozing     out  high while snoozed
//   buzzer       out  beep pattern
//   led_alarm    out  buzzer while ringing, steady 1 while snoozed, else 0
//   snooze_cnt   out  snoozes used in the current alarm event
//   missed       out  sticky flag: the alarm timed out unanswered
//
// Build option:
//   ALARM_ESCALATE_EN - when defined, the beep off-time becomes
//                       BEEP_OFF_TICKS >> snooze_cnt (minimum 1 cycle), so the
//                       beeping gets faster after each snooze.
// -----------------------------------------------------------------------------
module alarm_ring_controller #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3,
    parameter int BEEP_ON_TICKS  = 40,
    parameter int BEEP_OFF_TICKS = 40
) (
    input  logic        clk_200,
    input  logic        rst,
    input  logic        sec_tick,
    input  logic [15:0] time_hhmm,
    input  logic [15:0] alarm_hhmm,
    input  logic [7:0]  time_ss,
    input  logic        alarm_en,
    input  logic        adjusting,
    input  logic        btn_dismiss,
    input  logic        btn_snooze,
    output logic        ringing,
    output logic        snoozing,
    output logic        buzzer,
    output logic        led_alarm,
    output logic [2:0]  snooze_cnt,
    output logic        missed
);

    localparam int BEEP_MAX = (BEEP_ON_TICKS > BEEP_OFF_TICKS) ? BEEP_ON_TICKS : BEEP_OFF_TICKS;
    localparam int BEEP_W   = $clog2(BEEP_MAX + 1);

    // Terminal values are compared one tick early, so the state changes on the
    // sec_tick that makes the count reach its limit.
    localparam logic [7:0]        RING_LAST   = 8'(RING_TIMEOUT_S - 1);
    localparam logic [9:0]        SNOOZE_LAST = 10'(SNOOZE_MIN * 60 - 1);
    localparam logic [2:0]        SNOOZE_LIM  = 3'(MAX_SNOOZE);
    localparam logic [BEEP_W-1:0] ON_LAST     = BEEP_W'(BEEP_ON_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RINGING,
        S_SNOOZE,
        S_DISMISSED
    } state_t;

    state_t            state_q,      state_d;
    logic [7:0]        ring_sec_q,   ring_sec_d;
    logic [9:0]        snooze_sec_q, snooze_sec_d;
    logic [2:0]        snooze_cnt_q, snooze_cnt_d;
    logic              missed_q,     missed_d;
    logic [BEEP_W-1:0] beep_cnt_q,   beep_cnt_d;
    logic              beep_off_q,   beep_off_d;

    logic              match;
    logic [BEEP_W-1:0] off_last;

    assign match = alarm_en & ~adjusting &
                   (time_hhmm == alarm_hhmm) & (time_ss == 8'h00);

`ifdef ALARM_ESCALATE_EN
    logic [BEEP_W-1:0] off_ticks;

    // The off-time halves with each snooze, but it never drops below one cycle.
    always_comb begin
        off_ticks = BEEP_W'(BEEP_OFF_TICKS) >> snooze_cnt_q;
        if (off_ticks == '0) begin
            off_ticks = BEEP_W'(1);
        end
        off_last = off_ticks - BEEP_W'(1);
    end
`else
    assign off_last = BEEP_W'(BEEP_OFF_TICKS - 1);
`endif

    // Next-state and counter logic
    always_comb begin
        state_d      = state_q;
        ring_sec_d   = ring_sec_q;
        snooze_sec_d = snooze_sec_q;
        snooze_cnt_d = snooze_cnt_q;
        missed_d     = missed_q;
        beep_cnt_d   = '0;
        beep_off_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (btn_dismiss || btn_snooze) begin
                    missed_d = 1'b0;
                end
                if (match) begin
                    state_d      = S_RINGING;
                    snooze_cnt_d = '0;
                end
            end

            S_RINGING: begin
                if (sec_tick && (ring_sec_q != 8'hFF)) begin
                    ring_sec_d = ring_sec_q + 8'd1;
                end
                // Buttons outrank the timeout, so a press on the timeout tick
                // never sets missed.
                if (!alarm_en) begin
                    state_d = S_IDLE;
                end else if (btn_dismiss) begin
                    state_d = S_DISMISSED;
                end else if (btn_snooze) begin
                    if (snooze_cnt_q < SNOOZE_LIM) begin
                        state_d      = S_SNOOZE;
                        snooze_cnt_d = snooze_cnt_q + 3'd1;
                    end else begin
                        state_d = S_DISMISSED;
                    end
                end else if (sec_tick && (ring_sec_q >= RING_LAST)) begin
                    state_d  = S_DISMISSED;
                    missed_d = 1'b1;
                end
            end

            S_SNOOZE: begin
                if (sec_tick && (snooze_sec_q != 10'h3FF)) begin
                    snooze_sec_d = snooze_sec_q + 10'd1;
                end
                // Waking from snooze does not re-check match.
                if (!alarm_en) begin
                    state_d = S_IDLE;
                end else if (btn_dismiss) begin
                    state_d = S_DISMISSED;
                end else if (sec_tick && (snooze_sec_q >= SNOOZE_LAST)) begin
                    state_d = S_RINGING;
                end
            end

            S_DISMISSED: begin
                // Hold here for the rest of the matching minute so the alarm
                // does not re-trigger.
                if (!alarm_en || (time_hhmm != alarm_hhmm)) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Each counter stays at 0 outside its own state, so entering a state
        // always starts the count from 0.
        if (state_d != S_RINGING) begin
            ring_sec_d = '0;
        end
        if (state_d != S_SNOOZE) begin
            snooze_sec_d = '0;
        end
        if (state_d == S_IDLE) begin
            snooze_cnt_d = '0;
        end

        // The beep only advances while ringing continues. Any entry into
        // RINGING starts at the beginning of the ON phase.
        if ((state_q == S_RINGING) && (state_d == S_RINGING)) begin
            beep_cnt_d = beep_cnt_q + BEEP_W'(1);
            beep_off_d = beep_off_q;
            if (!beep_off_q && (beep_cnt_q >= ON_LAST)) begin
                beep_cnt_d = '0;
                beep_off_d = 1'b1;
            end else if (beep_off_q && (beep_cnt_q >= off_last)) begin
                beep_cnt_d = '0;
                beep_off_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_200 or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ring_sec_q   <= '0;
            snooze_sec_q <= '0;
            snooze_cnt_q <= '0;
            missed_q     <= 1'b0;
            beep_cnt_q   <= '0;
            beep_off_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_sec_q   <= ring_sec_d;
            snooze_sec_q <= snooze_sec_d;
            snooze_cnt_q <= snooze_cnt_d;
            missed_q     <= missed_d;
            beep_cnt_q   <= beep_cnt_d;
            beep_off_q   <= beep_off_d;
        end
    end

    // The outputs decode registered state only, so an async reset forces them
    // all to 0 at once.
    assign ringing    = (state_q == S_RINGING);
    assign snoozing   = (state_q == S_SNOOZE);
    assign buzzer     = ringing & ~beep_off_q;
    assign led_alarm  = ringing ? buzzer : snoozing;
    assign snooze_cnt = snooze_cnt_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_alarm_ring_controller.sv
module tb_alarm_ring_controller;

    logic        clk_200 = 1'b0;
    logic        rst;
    logic        sec_tick;
    logic [15:0] time_hhmm;
    logic [15:0] alarm_hhmm;
    logic [7:0]  time_ss;
    logic        alarm_en;
    logic        adjusting;
    logic        btn_dismiss;
    logic        btn_snooze;
    logic        ringing;
    logic        snoozing;
    logic        buzzer;
    logic        led_alarm;
    logic [2:0]  snooze_cnt;
    logic        missed;

    always #5 clk_200 = ~clk_200;

    alarm_ring_controller #(
        .SNOOZE_MIN    (1),
        .RING_TIMEOUT_S(5),
        .MAX_SNOOZE    (2),
        .BEEP_ON_TICKS (4),
        .BEEP_OFF_TICKS(4)
    ) dut (
        .clk_200    (clk_200),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .time_hhmm  (time_hhmm),
        .alarm_hhmm (alarm_hhmm),
        .time_ss    (time_ss),
        .alarm_en   (alarm_en),
        .adjusting  (adjusting),
        .btn_dismiss(btn_dismiss),
        .btn_snooze (btn_snooze),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .buzzer     (buzzer),
        .led_alarm  (led_alarm),
        .snooze_cnt (snooze_cnt),
        .missed     (missed)
    );

    // Output vector bit order: ringing, snoozing, buzzer, led_alarm, snooze_cnt[2:0], missed
    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] obs;
    logic       bexp;
    int         checks = 0;
    int         errors = 0;

    assign obs = {ringing, snoozing, buzzer, led_alarm, snooze_cnt, missed};

    task automatic exp_out(input string nm, input logic r, input logic s, input logic b,
                           input logic l, input logic [2:0] c, input logic m);
        exp_t e;
        e.name = nm;
        e.exp  = {r, s, b, l, c, m};
        sb.push_back(e);
    endtask

    task automatic step(input logic tk, input logic dis, input logic snz);
        sec_tick    = tk;
        btn_dismiss = dis;
        btn_snooze  = snz;
        @(posedge clk_200);
        #1;
        sec_tick    = 1'b0;
        btn_dismiss = 1'b0;
        btn_snooze  = 1'b0;
    endtask

    task automatic set_time(input logic [15:0] hhmm, input logic [7:0] ss);
        time_hhmm = hhmm;
        time_ss   = ss;
    endtask

    // Monitor: checks every queued expectation against the outputs at the falling edge.
    always @(negedge clk_200) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (obs !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: got r/s/b/l/cnt/m=%b required %b", mon_e.name, obs, mon_e.exp);
            end
        end
    end

    initial begin
        rst         = 1'b0;
        sec_tick    = 1'b0;
        btn_dismiss = 1'b0;
        btn_snooze  = 1'b0;
        alarm_en    = 1'b1;
        adjusting   = 1'b0;
        alarm_hhmm  = 16'h0730;
        set_time(16'h0729, 8'h59);
        #1 rst = 1'b1;
        @(posedge clk_200);
        #1;
        exp_out("reset_state", 0, 0, 0, 0, 3'd0, 0);
        step(0, 0, 0);
        rst = 1'b0;
        step(0, 0, 0);
        exp_out("idle_0729_59", 0, 0, 0, 0, 3'd0, 0);

        // Trigger and beep pattern: 4 on, 4 off
        set_time(16'h0730, 8'h00);
        step(0, 0, 0);
        exp_out("ring_start", 1, 0, 1, 1, 3'd0, 0);
        for (int k = 1; k < 12; k++) begin
            step(0, 0, 0);
            bexp = ((k % 8) < 4);
            exp_out($sformatf("beep_k%0d", k), 1, 0, bexp, bexp, 3'd0, 0);
        end

        // Timeout after the 5th tick
        for (int j = 1; j <= 4; j++) begin
            step(1, 0, 0);
            exp_out($sformatf("ring_tick%0d", j), 1, 0, 0, 0, 3'd0, 0);
        end
        step(1, 0, 0);
        exp_out("timeout_missed", 0, 0, 0, 0, 3'd0, 1);
        repeat (3) step(0, 0, 0);
        exp_out("no_retrigger_0730", 0, 0, 0, 0, 3'd0, 1);
        set_time(16'h0731, 8'h00);
        step(0, 0, 0);
        exp_out("idle_0731", 0, 0, 0, 0, 3'd0, 1);
        step(0, 0, 1);
        exp_out("button_clears_missed", 0, 0, 0, 0, 3'd0, 0);

        // Snooze limit
        set_time(16'h0730, 8'h00);
        step(0, 0, 0);
        exp_out("ring2_start", 1, 0, 1, 1, 3'd0, 0);
        set_time(16'h0730, 8'h01);
        step(0, 0, 1);
        exp_out("snooze1", 0, 1, 0, 1, 3'd1, 0);
        step(0, 0, 1);
        exp_out("snooze_btn_ignored", 0, 1, 0, 1, 3'd1, 0);
        repeat (59) step(1, 0, 0);
        exp_out("snooze1_59s", 0, 1, 0, 1, 3'd1, 0);
        step(1, 0, 0);
        exp_out("wake1", 1, 0, 1, 1, 3'd1, 0);
        step(0, 0, 1);
        exp_out("snooze2", 0, 1, 0, 1, 3'd2, 0);
        repeat (60) step(1, 0, 0);
        exp_out("wake2", 1, 0, 1, 1, 3'd2, 0);
        step(0, 0, 1);
        exp_out("snooze_limit_dismiss", 0, 0, 0, 0, 3'd2, 0);
        set_time(16'h0731, 8'h00);
        step(0, 0, 0);

        // Dismiss beats snooze in the same cycle
        set_time(16'h0730, 8'h00);
        step(0, 0, 0);
        exp_out("ring3_start", 1, 0, 1, 1, 3'd0, 0);
        step(0, 1, 1);
        exp_out("dismiss_beats_snooze", 0, 0, 0, 0, 3'd0, 0);
        step(0, 0, 0);
        exp_out("dismissed_hold", 0, 0, 0, 0, 3'd0, 0);
        set_time(16'h0731, 8'h00);
        step(0, 0, 0);

        // Button on the timeout tick: button wins, missed stays 0
        set_time(16'h0730, 8'h00);
        step(0, 0, 0);
        exp_out("ring4_start", 1, 0, 1, 1, 3'd0, 0);
        repeat (4) step(1, 0, 0);
        step(1, 1, 0);
        exp_out("button_beats_timeout", 0, 0, 0, 0, 3'd0, 0);
        set_time(16'h0731, 8'h00);
        step(0, 0, 0);

        // Blocking: adjusting blocks a trigger but does not abort; alarm_en drop
        adjusting = 1'b1;
        set_time(16'h0730, 8'h00);
        step(0, 0, 0);
        step(0, 0, 0);
        exp_out("adjust_blocks", 0, 0, 0, 0, 3'd0, 0);
        adjusting = 1'b0;
        step(0, 0, 0);
        exp_out("ring_after_adjust", 1, 0, 1, 1, 3'd0, 0);
        adjusting = 1'b1;
        step(0, 0, 0);
        exp_out("adjust_no_abort", 1, 0, 1, 1, 3'd0, 0);
        adjusting = 1'b0;
        set_time(16'h0730, 8'h01);
        step(0, 0, 1);
        exp_out("snooze_before_drop", 0, 1, 0, 1, 3'd1, 0);
        repeat (3) step(1, 0, 0);
        alarm_en = 1'b0;
        step(0, 0, 0);
        exp_out("en_drop_idle", 0, 0, 0, 0, 3'd0, 0);
        alarm_en = 1'b1;
        step(0, 0, 0);

        // Asynchronous reset mid-ring
        set_time(16'h0730, 8'h00);
        step(0, 0, 0);
        exp_out("ring5_start", 1, 0, 1, 1, 3'd0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        #1 rst = 1'b1;
        #1 exp_out("async_reset", 0, 0, 0, 0, 3'd0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        set_time(16'h0731, 8'h00);
        rst = 1'b0;
        step(0, 0, 0);
        exp_out("idle_after_reset", 0, 0, 0, 0, 3'd0, 0);

        repeat (2) @(negedge clk_200);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
